muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and HI/LO register width.
REQ-002 The block SHALL have parameter CNTW, default 6, the iteration counter width, sufficient to count WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start_multE  input  1  one-cycle request from execute stage to begin an operation.
REQ-006 opE  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 srcaE, srcbE  input  WIDTH  operands (multiplicand/dividend, multiplier/divisor), sampled with start_multE.
REQ-008 hi_we, lo_we  input  1  mthi/mtlo write enables; hi_wd, lo_wd  input  WIDTH  write data.
REQ-009 busy_multE  output  1  unit occupied; consumed by the hazard detector as a stall source.
REQ-010 done  output  1  one-cycle pulse when HI/LO receive a result.
REQ-011 hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-013 In IDLE with start_multE=1, the block SHALL latch operand magnitudes (signed ops) or raw values (unsigned ops), record result signs, clear the counter, and enter MUL (op 0x) or DIV (op 1x).
REQ-014 MUL SHALL perform one shift-add step per cycle for exactly WIDTH cycles into a 2*WIDTH-bit accumulator, then enter FIX.
REQ-015 DIV SHALL perform one restoring-division step per cycle for exactly WIDTH cycles, then enter FIX.
REQ-016 A divisor of zero SHALL skip iteration: DIV enters FIX after one cycle with quotient all-ones and remainder equal to the dividend, no sign correction.
REQ-017 FIX SHALL apply sign correction (product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign), write HI/LO, pulse done, and return to IDLE, all in one cycle.
REQ-018 Results: mult/multu HI=product[2W-1:W], LO=product[W-1:0]; div/divu LO=quotient, HI=remainder.
REQ-019 busy_multE SHALL be 1 exactly in MUL, DIV and FIX; with start at cycle 0, busy is high cycles 1..WIDTH+1, done pulses in cycle WIDTH+1, HI/LO new values visible from cycle WIDTH+2.
REQ-020 start_multE while not IDLE SHALL be ignored.
REQ-021 hi_we/lo_we SHALL update HI/LO on the next edge only in IDLE without start_multE; otherwise the write is dropped.
REQ-022 Counter SHALL saturate-free wrap only within CNTW bits; WIDTH must be <= 2^CNTW - 1.

Reset
REQ-023 reset low SHALL asynchronously force IDLE, counter 0, accumulators 0, hi=0, lo=0, busy_multE=0, done=0, including mid-operation (result discarded).
REQ-024 Release of reset SHALL not start an operation; the first start_multE after release is honoured normally.

Configuration
REQ-025 Macro MULDIV_DIV_EN SHALL compile in the divider; defined: ops 10/11 behave per REQ-015..018.
REQ-026 Without MULDIV_DIV_EN, ops 10/11 SHALL be accepted as a single-cycle no-op: no busy, no done, HI/LO unchanged; DIV state and divider logic absent.

Verification
REQ-027 multu 0xFFFFFFFF*0x00000002 at cycle 0 -> busy cycles 1..33, done cycle 33, HI=0x00000001 LO=0xFFFFFFFE at cycle 34.
REQ-028 mult 0xFFFFFFFD(-3)*0x00000007 -> HI=0xFFFFFFFF LO=0xFFFFFFEB.
REQ-029 div 0xFFFFFFF9(-7)/0x00000002 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; divu 7/0 -> done after 2 cycles, LO=0xFFFFFFFF HI=0x00000007.
REQ-030 Second start_multE at cycle 5 of a mult -> ignored, single done, result of first op only.
REQ-031 reset low at cycle 10 of a mult -> busy 0 and HI=LO=0 immediately; hi_we with 0x1234 in IDLE -> HI=0x1234 next cycle; hi_we during busy -> HI unchanged.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer with architectural HI/LO registers.
// Optional divider compiled in with `define MULDIV_DIV_EN.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_multE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wd,
  input  logic [WIDTH-1:0] lo_wd,
  output logic             busy_multE,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned SW = WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Operand magnitudes for signed ops; unsigned ops pass through
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [SW-1:0]    mul_sum;
  logic [AW-1:0]    prod_fix;

  assign is_signed = ~opE[0];
  assign a_neg     = is_signed & srcaE[WIDTH-1];
  assign b_neg     = is_signed & srcbE[WIDTH-1];
  assign a_mag     = a_neg ? (WIDTH'(0) - srcaE) : srcaE;
  assign b_mag     = b_neg ? (WIDTH'(0) - srcbE) : srcbE;
  assign mul_sum   = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : SW'(0));
  assign prod_fix  = neg_q ? (AW'(0) - acc_q) : acc_q;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] b_q, b_d;
  logic             rneg_q, rneg_d, is_div_q, is_div_d;
  logic [SW-1:0]    rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub, quo_fix, rem_fix;

  // Restoring step: shift next dividend bit into the partial remainder
  assign rem_sh  = acc_q[AW-1:WIDTH-1];
  assign div_ge  = rem_sh >= {1'b0, b_q};
  assign div_sub = WIDTH'(rem_sh - {1'b0, b_q});
  assign quo_fix = neg_q  ? (WIDTH'(0) - acc_q[WIDTH-1:0])  : acc_q[WIDTH-1:0];
  assign rem_fix = rneg_q ? (WIDTH'(0) - acc_q[AW-1:WIDTH]) : acc_q[AW-1:WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
    b_d      = b_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_multE) begin
          cnt_d = '0;
          neg_d = a_neg ^ b_neg;
          if (!opE[1]) begin
            a_d     = a_mag;
            acc_d   = {WIDTH'(0), b_mag};
            state_d = MUL;
`ifdef MULDIV_DIV_EN
            is_div_d = 1'b0;
          end else begin
            is_div_d = 1'b1;
            b_d      = b_mag;
            acc_d    = {WIDTH'(0), a_mag};
            state_d  = DIV;
            // Zero divisor keeps the raw dividend and suppresses sign fixup
            if (srcbE == '0) begin
              a_d    = srcaE;
              neg_d  = 1'b0;
              rneg_d = 1'b0;
            end else begin
              a_d    = a_mag;
              rneg_d = a_neg;
            end
`endif
          end
        end else begin
          if (hi_we) hi_d = hi_wd;
          if (lo_we) lo_d = lo_wd;
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIDTH - 1)) state_d = FIX;
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        if (b_q == '0) begin
          acc_d   = {a_q, {WIDTH{1'b1}}};
          state_d = FIX;
        end else begin
          acc_d = {(div_ge ? div_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(WIDTH - 1)) state_d = FIX;
        end
      end
`endif
      FIX: begin
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[AW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`else
        hi_d = prod_fix[AW-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      b_q      <= '0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      b_q      <= b_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
`endif
    end
  end

  assign busy_multE = busy_q;
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases plus randomized traffic against
// an arithmetic reference model of HI/LO, busy and done.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_multE;
  logic [1:0]  opE;
  logic [31:0] srcaE, srcbE;
  logic        hi_we, lo_we;
  logic [31:0] hi_wd, lo_wd;
  logic        busy_multE, done;
  logic [31:0] hi, lo;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start_multE(start_multE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .hi_we(hi_we), .lo_we(lo_we),
    .hi_wd(hi_wd), .lo_wd(lo_wd), .busy_multE(busy_multE), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  // Reference model: cycles left busy, pending result, architectural HI/LO
  int          m_rem;
  logic [63:0] m_res;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    case (op)
      2'b00: begin sa = $signed(a); sb = $signed(b); q = sa * sb; res = q; end
      2'b01: begin res = {32'b0, a} * {32'b0, b}; end
      default: begin
        if (b == 32'b0) res = {a, 32'hFFFFFFFF};
        else begin
          if (op == 2'b10) begin sa = $signed(a); sb = $signed(b); end
          else begin sa = {32'b0, a}; sb = {32'b0, b}; end
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic model_clear();
    m_rem = 0; m_res = '0; m_hi = '0; m_lo = '0;
  endtask

  task automatic model_update();
    if (!reset) model_clear();
    else if (m_rem > 0) begin
      if (m_rem == 1) {m_hi, m_lo} = m_res;
      m_rem--;
    end else if (start_multE) begin
`ifdef MULDIV_DIV_EN
      m_res = calc(opE, srcaE, srcbE);
      m_rem = (opE[1] && srcbE == 32'b0) ? 2 : 33;
`else
      if (!opE[1]) begin
        m_res = calc(opE, srcaE, srcbE);
        m_rem = 33;
      end
`endif
    end else begin
      if (hi_we) m_hi = hi_wd;
      if (lo_we) m_lo = lo_wd;
    end
  endtask

  task automatic compare();
    chk("busy", {31'b0, busy_multE}, {31'b0, m_rem > 0});
    chk("done", {31'b0, done}, {31'b0, m_rem == 1});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (done) done_seen++;
  endtask

  // Called at a negedge: drive, clock, update model, compare at next negedge
  task automatic step(input logic st, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic hwe, input logic lwe, input logic [31:0] hwd, input logic [31:0] lwd);
    start_multE = st; opE = op; srcaE = a; srcbE = b;
    hi_we = hwe; lo_we = lwe; hi_wd = hwd; lo_wd = lwd;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 32'b0, 32'b0, 1'b0, 1'b0, 32'b0, 32'b0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    step(1'b1, op, a, b, 1'b0, 1'b0, 32'b0, 32'b0);
    n = 0;
    while (m_rem > 0 && n < 100) begin idle(); n++; end
    if (n >= 100) begin n_err++; $display("FAIL timeout: got busy expected idle"); end
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_clear();
    compare();
    idle();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      4: begin v = $urandom_range(0, 15); if ($urandom_range(0, 1) == 1) v = -v; end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    start_multE = 0; opE = 0; srcaE = 0; srcbE = 0;
    hi_we = 0; lo_we = 0; hi_wd = 0; lo_wd = 0;
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    compare();
    @(negedge clk);
    reset = 1'b1;

    // Pin the model against hand-computed results
    chk("model_mult", calc(2'b00, 32'hFFFFFFFD, 32'h7)  [31:0], 32'hFFFFFFEB);
    chk("model_div",  calc(2'b10, 32'hFFFFFFF9, 32'h2)  [31:0], 32'hFFFFFFFD);

    // multu timing and result
    step(1'b1, 2'b01, 32'hFFFFFFFF, 32'h2, 1'b0, 1'b0, 32'b0, 32'b0);
    chk("multu_busy_c1", {31'b0, busy_multE}, 32'h1);
    repeat (31) idle();
    chk("multu_done_c32", {31'b0, done}, 32'h0);
    idle();
    chk("multu_done_c33", {31'b0, done}, 32'h1);
    chk("multu_busy_c33", {31'b0, busy_multE}, 32'h1);
    idle();
    chk("multu_busy_c34", {31'b0, busy_multE}, 32'h0);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    run_op(2'b00, 32'hFFFFFFFD, 32'h7);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'hFFFFFFF9, 32'h2);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    step(1'b1, 2'b11, 32'h7, 32'h0, 1'b0, 1'b0, 32'b0, 32'b0);
    idle();
    chk("divz_done_c2", {31'b0, done}, 32'h1);
    idle();
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_hi", hi, 32'h00000007);
`else
    step(1'b1, 2'b10, 32'hFFFFFFF9, 32'h2, 1'b0, 1'b0, 32'b0, 32'b0);
    chk("div_noop_busy", {31'b0, busy_multE}, 32'h0);
    chk("div_noop_hi", hi, 32'hFFFFFFFF);
    chk("div_noop_lo", lo, 32'hFFFFFFEB);
`endif

    // Second start mid-operation is ignored
    done_seen = 0;
    step(1'b1, 2'b01, 32'h5, 32'h6, 1'b0, 1'b0, 32'b0, 32'b0);
    repeat (4) idle();
    step(1'b1, 2'b01, 32'h100, 32'h100, 1'b0, 1'b0, 32'b0, 32'b0);
    repeat (40) idle();
    chk("restart_dones", done_seen, 32'h1);
    chk("restart_lo", lo, 32'd30);
    chk("restart_hi", hi, 32'h0);

    // Reset mid-operation, then mthi in IDLE and during busy
    step(1'b1, 2'b00, 32'h3, 32'h4, 1'b0, 1'b0, 32'b0, 32'b0);
    repeat (9) idle();
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy_multE}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    model_clear();
    idle();
    reset = 1'b1;
    idle();
    chk("rst_no_start", {31'b0, busy_multE}, 32'h0);
    step(1'b0, 2'b00, 32'b0, 32'b0, 1'b1, 1'b0, 32'h1234, 32'b0);
    chk("mthi_idle", hi, 32'h1234);
    step(1'b1, 2'b00, 32'h2, 32'h2, 1'b0, 1'b0, 32'b0, 32'b0);
    step(1'b0, 2'b00, 32'b0, 32'b0, 1'b1, 1'b1, 32'h5555, 32'h6666);
    chk("mthi_busy", hi, 32'h1234);
    repeat (40) idle();
    chk("after_hi", hi, 32'h0);
    chk("after_lo", lo, 32'h4);

    // Randomized traffic including starts while busy, writes and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      else step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd(),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom, $urandom);
    end
    repeat (40) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
